// File: rtl/avst_ready_latency_source_adapter_if.sv
// Avalon-ST bundle for the readyLatency adapter: upstream (RL=0) side,
// downstream (RL=N) side and the framing/occupancy status outputs.
interface avst_ready_latency_source_adapter_if #(
  parameter int DATA_WIDTH = 37,
  parameter int ADDR_WIDTH = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH:0]   fill_level;
  logic [15:0]           pkt_count;
  logic                  err_sop;
  logic                  err_nosop;

  // The adapter itself sits on the slave side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, fill_level, pkt_count, err_sop, err_nosop
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, fill_level, pkt_count, err_sop, err_nosop
  );
endinterface

// File: rtl/avst_ready_latency_source_adapter.sv
// Adapts a readyLatency=0 source to a readyLatency=READY_LATENCY sink through a
// DEPTH-entry skid buffer, with an inline SOP/EOP framing monitor.
module avst_ready_latency_source_adapter #(
  parameter int READY_LATENCY = 1,
  parameter int DEPTH         = 4,
  parameter int ADDR_WIDTH    = 2,
  parameter int DATA_WIDTH    = 37
) (
  input  logic clk,
  input  logic reset_n,
  avst_ready_latency_source_adapter_if.slave bus
);

  localparam int CNT_W   = ADDR_WIDTH + 1;
  localparam int SOP_BIT = 32;
  localparam int EOP_BIT = 33;

  typedef enum logic {S_IDLE, S_INPKT} state_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  grant;
  logic                  push, pop;

  state_t                state_q, state_d;
  logic                  err_sop_q, err_sop_d;
  logic                  err_nosop_q, err_nosop_d;
  logic                  pkt_inc;
  logic [15:0]           pkt_count_q;
  logic                  sop, eop;

  assign push = bus.in_valid && in_ready_q;
  assign pop  = grant && (count_q != '0);
  assign sop  = bus.in_data[SOP_BIT];
  assign eop  = bus.in_data[EOP_BIT];

  // grant is the out_ready value seen READY_LATENCY-1 cycles before the output edge.
  generate
    if (READY_LATENCY == 1) begin : g_rl1
      assign grant = bus.out_ready;
    end else begin : g_rln
      logic [READY_LATENCY-2:0] rdy_pipe_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rdy_pipe_q <= '0;
        end else begin
          rdy_pipe_q[0] <= bus.out_ready;
          for (int i = 1; i < READY_LATENCY - 1; i++) begin
            rdy_pipe_q[i] <= rdy_pipe_q[i-1];
          end
        end
      end
      assign grant = rdy_pipe_q[READY_LATENCY-2];
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Storage array carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      count_q     <= count_d;
      in_ready_q  <= (count_d < CNT_W'(DEPTH));
      out_valid_q <= pop;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + ADDR_WIDTH'(1);
        out_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // Framing monitor: state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An EOP always closes the current packet; any other accepted beat leaves one open.
  always_comb begin
    state_d = state_q;
    if (push) begin
      state_d = eop ? S_IDLE : S_INPKT;
    end
  end

  always_comb begin
    err_sop_d   = 1'b0;
    err_nosop_d = 1'b0;
    pkt_inc     = 1'b0;
    if (push) begin
      pkt_inc = eop;
      case (state_q)
        S_IDLE:  err_nosop_d = !sop;
        S_INPKT: err_sop_d   = sop;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_sop_q   <= 1'b0;
      err_nosop_q <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      err_sop_q   <= err_sop_d;
      err_nosop_q <= err_nosop_d;
      if (pkt_inc) begin
        pkt_count_q <= pkt_count_q + 16'd1;
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.fill_level = count_q;
  assign bus.pkt_count  = pkt_count_q;
  assign bus.err_sop    = err_sop_q;
  assign bus.err_nosop  = err_nosop_q;

endmodule
